// File: rtl/rst_clk_seq_ctrl.sv
// ============================================================================
//  Module   : rst_clk_seq_ctrl
//  Purpose  : Power-on / re-sequence controller for NUM_CH reset domains:
//             gate clocks, assert resets, staggered release, ungate, settle.
//  Options  : RST_SEQ_STAGGER_EN - ungate clock enables one channel per cycle
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_clk_seq_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int GATE_CYC   = 2,
  parameter int ASSERT_CYC = 5,
  parameter int HOLD_CYC   = 5,
  parameter int SETTLE_CYC = 10
) (
  input  logic                    i_refclk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [NUM_CH*CNT_W-1:0] i_dly,
  output logic [NUM_CH-1:0]       o_rst_n,
  output logic [NUM_CH-1:0]       o_clk_en,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_start_ovr,
  output logic [2:0]              o_state
);

  localparam int c_tw      = CNT_W + $clog2(NUM_CH) + 1;
  localparam int c_max_ga  = (GATE_CYC > ASSERT_CYC) ? GATE_CYC : ASSERT_CYC;
  localparam int c_max_hs  = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
  localparam int c_max_cyc = (c_max_ga > c_max_hs) ? c_max_ga : c_max_hs;
  localparam int c_cnt_w   = $clog2(c_max_cyc + 1);
  localparam int c_ug_w    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [c_cnt_w-1:0] c_gate_ld   = c_cnt_w'(GATE_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_assert_ld = c_cnt_w'(ASSERT_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_hold_ld   = c_cnt_w'(HOLD_CYC - 1);
  // UNGATE itself accounts for the first settle cycle
  localparam logic [c_cnt_w-1:0] c_settle_ld = c_cnt_w'((SETTLE_CYC >= 2) ? SETTLE_CYC - 2 : 0);
  localparam logic [c_ug_w-1:0]  c_ug_last   = c_ug_w'(NUM_CH - 1);

`ifdef RST_SEQ_STAGGER_EN
  localparam bit c_stagger = 1'b1;
`else
  localparam bit c_stagger = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GATE    = 3'd1,
    S_ASSERT  = 3'd2,
    S_RELEASE = 3'd3,
    S_HOLD    = 3'd4,
    S_UNGATE  = 3'd5,
    S_SETTLE  = 3'd6
  } state_t;

  state_t                    r_state;
  logic [c_cnt_w-1:0]        r_cnt;
  logic [c_tw-1:0]           r_rel_cnt;
  logic [c_ug_w-1:0]         r_ug_idx;
  logic [NUM_CH*CNT_W-1:0]   r_dly;
  logic [NUM_CH-1:0]         r_rst_n;
  logic [NUM_CH-1:0]         r_clk_en;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_start_ovr;

  logic [c_tw-1:0]           w_tsum [NUM_CH];
  logic [c_tw-1:0]           w_acc;
  logic [NUM_CH-1:0]         w_rel_mask;

  // Cumulative release times; width leaves headroom so the sum cannot wrap
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_acc     = w_acc + c_tw'(r_dly[k*CNT_W +: CNT_W]);
      w_tsum[k] = w_acc;
    end
  end

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_rel
      assign w_rel_mask[k] = (w_tsum[k] <= r_rel_cnt);
    end
  endgenerate

  always_ff @(posedge i_refclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rel_cnt   <= '0;
      r_ug_idx    <= '0;
      r_dly       <= '0;
      r_rst_n     <= '0;
      r_clk_en    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_start_ovr <= 1'b0;
    end else begin
      r_start_ovr <= i_start && r_busy;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_dly     <= i_dly;
            r_state   <= S_GATE;
            r_cnt     <= c_gate_ld;
            r_rel_cnt <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_clk_en  <= '0;
          end
        end
        S_GATE: begin
          if (r_cnt == '0) begin
            r_state <= S_ASSERT;
            r_cnt   <= c_assert_ld;
            r_rst_n <= '0;
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        S_ASSERT: begin
          if (r_cnt == '0) begin
            // Channels with zero cumulative delay release on this same edge
            r_rst_n   <= w_rel_mask;
            r_rel_cnt <= c_tw'(1);
            if (w_rel_mask[NUM_CH-1]) begin
              r_state <= S_HOLD;
              r_cnt   <= c_hold_ld;
            end else begin
              r_state <= S_RELEASE;
            end
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        S_RELEASE: begin
          r_rst_n <= w_rel_mask;
          if (w_rel_mask[NUM_CH-1]) begin
            r_state <= S_HOLD;
            r_cnt   <= c_hold_ld;
          end else begin
            r_rel_cnt <= r_rel_cnt + c_tw'(1);
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_state  <= S_UNGATE;
            r_clk_en <= c_stagger ? NUM_CH'(1) : '1;
            r_ug_idx <= c_stagger ? '0 : c_ug_last;
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        S_UNGATE: begin
          if (r_ug_idx == c_ug_last) begin
            if (SETTLE_CYC > 1) begin
              r_state <= S_SETTLE;
              r_cnt   <= c_settle_ld;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_ug_idx <= r_ug_idx + c_ug_w'(1);
            r_clk_en <= (r_clk_en << 1) | NUM_CH'(1);
          end
        end
        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rst_n     = r_rst_n;
  assign o_clk_en    = r_clk_en;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_start_ovr = r_start_ovr;
  assign o_state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_rst_clk_seq_ctrl.sv
// ============================================================================
//  Module   : tb_rst_clk_seq_ctrl
//  Purpose  : Self-checking bench for rst_clk_seq_ctrl (default parameters).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_clk_seq_ctrl;

`ifdef RST_SEQ_STAGGER_EN
  localparam bit c_stag = 1'b1;
`else
  localparam bit c_stag = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dly = '0;
  logic [3:0]  dut_rst_n;
  logic [3:0]  dut_clk_en;
  logic        busy;
  logic        done;
  logic        start_ovr;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;
  logic [3:0]  last_rst = 4'h0;
  logic [13:0] exp_q [$];

  rst_clk_seq_ctrl dut (
    .i_refclk    (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_dly       (dly),
    .o_rst_n     (dut_rst_n),
    .o_clk_en    (dut_clk_en),
    .o_busy      (busy),
    .o_done      (done),
    .o_start_ovr (start_ovr),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] observed();
    return {dut_rst_n, dut_clk_en, busy, done, start_ovr, state};
  endfunction

  task automatic chk(input string tag, input int n, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  function automatic int last_t(input logic [31:0] d);
    return int'(d[7:0]) + int'(d[15:8]) + int'(d[23:16]) + int'(d[31:24]);
  endfunction

  // Expected outputs after edge En of a sequence started at E0 (G=2, A=5, H=5, S=10)
  function automatic logic [13:0] model(input int n, input logic [31:0] d,
                                        input logic [3:0] prev_rst, input bit ovr);
    int t[4];
    int acc, tl, u, l;
    logic [3:0] r, c;
    logic b, dn;
    logic [2:0] s;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      acc  = acc + int'(d[k*8 +: 8]);
      t[k] = acc;
    end
    tl = t[3];
    u  = 12 + tl;
    l  = u + (c_stag ? 3 : 0);
    b = 1'b1; dn = 1'b0; c = 4'h0; r = 4'hF;
    if (n < 2) begin
      s = 3'd1; r = prev_rst;
    end else if (n < 7) begin
      s = 3'd2; r = 4'h0;
    end else if (n < 7 + tl) begin
      s = 3'd3;
      for (int k = 0; k < 4; k++) r[k] = (n - 7 >= t[k]);
    end else if (n < u) begin
      s = 3'd4;
    end else if (n <= l) begin
      s = 3'd5;
      for (int k = 0; k < 4; k++) c[k] = c_stag ? (n - u >= k) : 1'b1;
    end else if (n < l + 10) begin
      s = 3'd6; c = 4'hF;
    end else begin
      s = 3'd0; c = 4'hF; b = 1'b0; dn = 1'b1;
    end
    return {r, c, b, dn, ovr, s};
  endfunction

  // Start a sequence on the next edge (E0); expectations are queued up front
  // and popped one per edge. abort_at > 0 stops checking before edge abort_at.
  task automatic run_seq(input string tag, input logic [31:0] d, input int ovr_from,
                         input int ovr_to, input int chg_at, input int abort_at);
    int last, n;
    last = 12 + last_t(d) + (c_stag ? 3 : 0) + 10 + 2;
    if (abort_at > 0) last = abort_at - 1;
    for (int i = 0; i <= last; i++)
      exp_q.push_back(model(i, d, last_rst, (i >= ovr_from) && (i <= ovr_to)));
    dly   = d;
    start = 1'b1;
    n = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      chk(tag, n, observed(), exp_q.pop_front());
      start = (n + 1 >= ovr_from) && (n + 1 <= ovr_to);
      if (n + 1 == chg_at) dly = 32'hFFFF_FFFF;
      n++;
    end
    start = 1'b0;
    if (abort_at == 0) last_rst = 4'hF;
  endtask

  initial begin
    #2;
    chk("reset_state", 0, observed(), 14'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("no_autostart", 0, observed(), 14'h0);

    // D[0]=3, D[1]=0, D[2]=2, D[3]=1
    run_seq("basic", 32'h01_02_00_03, 1, 0, -1, 0);
    run_seq("ovr_pulse_dly_change", 32'h01_02_00_03, 5, 5, 3, 0);
    run_seq("start_held", 32'h01_02_00_03, 1, 2, -1, 0);
    run_seq("all_zero", 32'h00_00_00_00, 1, 0, -1, 0);

    run_seq("pre_abort", 32'h01_02_00_03, 1, 0, -1, 11);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk("abort_immediate", 11, observed(), 14'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_rst = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort_stays_idle", i, observed(), 14'h0);
    end

    run_seq("after_abort_zero", 32'h00_00_00_00, 1, 0, -1, 0);
    run_seq("max_delay", 32'hFF_FF_FF_FF, 1, 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rst_clk_seq_ctrl.md
Name: rst_clk_seq_ctrl

Overview:
- Parametrised, synthesisable power-on / re-sequence controller for NUM_CH reset domains.
- Each sequence runs: gate all clocks, assert all resets, release resets in channel order with per-channel programmable delays, hold, ungate clocks, settle, flag done.
- Sits between the PHY top-level reset inputs and the per-domain reset/clock-enable fabric.
- Software- or bench-triggered via a start pulse; replaces fixed-timing reset sequences with a configurable one.

Parameters:
- NUM_CH, 4, number of reset/clock domains (1..16).
- CNT_W, 8, width of each per-channel release delay field.
- GATE_CYC, 2, cycles clocks are gated before reset assertion (>=1).
- ASSERT_CYC, 5, cycles all resets are held asserted (>=1).
- HOLD_CYC, 5, cycles between the last reset release and clock ungate (>=1).
- SETTLE_CYC, 10, cycles after ungate before done (>=1).

Ports:
- i_refclk  in  1  sequencer clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle start request.
- i_dly  in  NUM_CH*CNT_W  channel k delay D[k] in bits [k*CNT_W +: CNT_W].
- o_rst_n  out  NUM_CH  per-channel active-low reset.
- o_clk_en  out  NUM_CH  per-channel clock enable.
- o_busy  out  1  sequence in progress.
- o_done  out  1  sticky: last sequence completed.
- o_start_ovr  out  1  one-cycle pulse: i_start ignored because busy.
- o_state  out  3  FSM state encoding, for debug.

Behaviour:
- Reset state (i_rst_n low, takes effect immediately):
  - o_rst_n = 0, o_clk_en = 0, o_busy = 0, o_done = 0, o_start_ovr = 0.
  - FSM = IDLE; counters = 0.
  - No auto-start on reset release.
- Timeline: E0 = edge sampling i_start = 1 while not busy. En = n edges later. All outputs are registered.
- State encoding: IDLE=0, GATE=1, ASSERT=2, RELEASE=3, HOLD=4, UNGATE=5, SETTLE=6.
- At E0:
  - i_dly is snapshotted; later changes to i_dly have no effect on this sequence.
  - Enter GATE: o_busy=1, o_done=0, o_clk_en=0. o_rst_n unchanged.
- GATE lasts GATE_CYC cycles. After E(G): ASSERT, o_rst_n all 0.
- ASSERT lasts ASSERT_CYC cycles. After E(G+A): RELEASE; release counter starts at 0.
- RELEASE:
  - T_k = D[0]+...+D[k], computed at width CNT_W+clog2(NUM_CH)+1 with no overflow.
  - o_rst_n[k] rises after edge E(G+A+T_k).
  - D=0 releases a channel in the same cycle as its predecessor; several channels may rise on one edge.
  - Release order is monotonic in k; a channel never re-asserts mid-sequence.
- After the last channel releases, at E(G+A+T_{N-1}): enter HOLD.
- HOLD lasts HOLD_CYC cycles; then UNGATE: o_clk_en all 1 after E(G+A+T+H).
- SETTLE lasts SETTLE_CYC cycles; then IDLE: o_busy=0, o_done=1 after E(G+A+T+H+S).
- o_done stays 1 until the next accepted start.
- i_start while o_busy=1: ignored; o_start_ovr=1 for exactly one cycle after that edge.
- i_start in IDLE with o_done=1: accepted as a normal restart.
- i_rst_n low mid-sequence: immediate reset state; the sequence is abandoned and not resumed.
- i_start held high for several cycles: first cycle starts the sequence; each later high cycle while busy gives an o_start_ovr pulse.

Optional Feature:
- Macro: RST_SEQ_STAGGER_EN.
- Defined:
  - In UNGATE, o_clk_en[k] rises after E(U+k), where U is the ungate edge.
  - SETTLE starts after the last enable rises, so done is delayed by NUM_CH-1 cycles.
  - o_state shows UNGATE for NUM_CH cycles.
- Undefined: all o_clk_en bits rise together at U; UNGATE lasts one cycle.

Test Plan:
1. Defaults, D={3,0,2,1}, start at E0:
   - o_clk_en=0 after E0; o_rst_n=0 after E2.
   - ch0 and ch1 rst_n rise after E10, ch2 after E12, ch3 after E13.
   - o_clk_en=0xF after E18; o_busy=0 and o_done=1 after E28.
2. Same as scenario 1 with RST_SEQ_STAGGER_EN:
   - o_clk_en bits rise after E18, E19, E20, E21 in order.
   - o_done after E31.
3. All D=0 -> all o_rst_n rise together after E7; o_clk_en after E12; done after E22.
4. i_start pulsed at E5 during a sequence -> o_start_ovr=1 for one cycle; timing identical to scenario 1.
   - Additionally, change i_dly to all-0xFF at E3 -> ignored; timing still identical to scenario 1.
5. i_rst_n low at E11 of scenario 1 -> immediately o_rst_n=0, o_clk_en=0, busy=0, done=0, state=0.
   - After release: stays IDLE until a new i_start.
6. D={255,255,255,255} -> ch3 releases after E(7+1020); no overflow; done after E1042.
